// File: rtl/and4.sv
// Registered 4-bit bitwise AND with a one-cycle valid pipeline.
// Also registers zero, all-ones and population-count flags alongside the result.
module and4 (
   input  logic       clk,
   input  logic       rst,
   input  logic [3:0] a,
   input  logic [3:0] b,
   input  logic       in_valid,
   output logic [3:0] y,
   output logic       out_valid,
   output logic       zero,
   output logic       all_ones,
   output logic [2:0] ones_cnt
);

   logic [3:0] y_q, y_d;
   logic       vld_q, vld_d;
   logic       zero_q, zero_d;
   logic       all_ones_q, all_ones_d;
   logic [2:0] cnt_q, cnt_d;
   logic [3:0] and_res;

   function automatic logic [2:0] popcnt4(input logic [3:0] v);
      return {2'b00, v[0]} + {2'b00, v[1]} + {2'b00, v[2]} + {2'b00, v[3]};
   endfunction

   assign and_res = a & b;

   always_comb begin
      y_d        = y_q;
      zero_d     = zero_q;
      all_ones_d = all_ones_q;
      cnt_d      = cnt_q;
      vld_d      = in_valid;
      // Operands are only looked at when valid, so X/Z on idle cycles never leaks in.
      if (in_valid) begin
         y_d        = and_res;
         zero_d     = (and_res == 4'b0000);
         all_ones_d = (and_res == 4'b1111);
         cnt_d      = popcnt4(and_res);
      end
   end

   // Stage boundary: result and flags registered together on the same edge.
   always_ff @(posedge clk) begin
      if (rst) begin
         y_q        <= 4'b0000;
         zero_q     <= 1'b1;
         all_ones_q <= 1'b0;
         cnt_q      <= 3'd0;
         vld_q      <= 1'b0;
      end else begin
         y_q        <= y_d;
         zero_q     <= zero_d;
         all_ones_q <= all_ones_d;
         cnt_q      <= cnt_d;
         vld_q      <= vld_d;
      end
   end

   assign y         = y_q;
   assign out_valid = vld_q;
   assign zero      = zero_q;
   assign all_ones  = all_ones_q;
   assign ones_cnt  = cnt_q;

endmodule

// File: tb/tb_and4.sv
// Directed self-checking bench for and4: reset, sweeps, hold, reset priority, exhaustive.
module tb_and4;

   logic       clk;
   logic       rst;
   logic [3:0] a;
   logic [3:0] b;
   logic       in_valid;
   logic [3:0] y;
   logic       out_valid;
   logic       zero;
   logic       all_ones;
   logic [2:0] ones_cnt;

   int checks;
   int errors;

   and4 dut (
      .clk      (clk),
      .rst      (rst),
      .a        (a),
      .b        (b),
      .in_valid (in_valid),
      .y        (y),
      .out_valid(out_valid),
      .zero     (zero),
      .all_ones (all_ones),
      .ones_cnt (ones_cnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Packed view of all outputs: {y, zero, all_ones, ones_cnt, out_valid}.
   function automatic logic [9:0] pack_exp(input logic [3:0] r, input logic v);
      logic [2:0] c;
      c = 3'd0;
      for (int i = 0; i < 4; i++) c = c + {2'b00, r[i]};
      return {r, (r == 4'b0000), (r == 4'b1111), c, v};
   endfunction

   function automatic logic [9:0] obs();
      return {y, zero, all_ones, ones_cnt, out_valid};
   endfunction

   task automatic step(input logic r, input logic v, input logic [3:0] av, input logic [3:0] bv);
      rst = r; in_valid = v; a = av; b = bv;
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      step(1'b1, 1'b0, 4'b0000, 4'b0000);
      checks++;
      if (obs() !== 10'b0000_1_0_000_0) begin
         errors++;
         $display("FAIL reset_edge1 got=%b expected=%b", obs(), 10'b0000_1_0_000_0);
      end
      step(1'b1, 1'b0, 4'b0000, 4'b0000);
      step(1'b0, 1'b0, 4'b0000, 4'b0000);
      checks++;
      if (obs() !== 10'b0000_1_0_000_0) begin
         errors++;
         $display("FAIL reset_after_release got=%b expected=%b", obs(), 10'b0000_1_0_000_0);
      end
   endtask

   task automatic test_sweep(input logic [3:0] bv);
      for (int i = 0; i < 16; i++) begin
         logic [3:0] av;
         av = i[3:0];
         step(1'b0, 1'b1, av, bv);
         checks++;
         if (obs() !== pack_exp(av & bv, 1'b1)) begin
            errors++;
            $display("FAIL sweep b=%b a=%b got=%b expected=%b", bv, av, obs(), pack_exp(av & bv, 1'b1));
         end
      end
   endtask

   task automatic test_examples();
      step(1'b0, 1'b1, 4'b1111, 4'b1010);
      checks++;
      if ({y, ones_cnt, zero} !== {4'b1010, 3'd2, 1'b0}) begin
         errors++;
         $display("FAIL ex_1111_1010 got y=%b cnt=%0d zero=%b expected y=1010 cnt=2 zero=0", y, ones_cnt, zero);
      end
      step(1'b0, 1'b1, 4'b0101, 4'b1010);
      checks++;
      if ({y, zero} !== {4'b0000, 1'b1}) begin
         errors++;
         $display("FAIL ex_0101_1010 got y=%b zero=%b expected y=0000 zero=1", y, zero);
      end
      step(1'b0, 1'b1, 4'b1110, 4'b1100);
      checks++;
      if ({y, ones_cnt, out_valid} !== {4'b1100, 3'd2, 1'b1}) begin
         errors++;
         $display("FAIL ex_1110_1100 got y=%b cnt=%0d ov=%b expected y=1100 cnt=2 ov=1", y, ones_cnt, out_valid);
      end
   endtask

   task automatic test_hold();
      step(1'b0, 1'b1, 4'b1111, 4'b1111);
      checks++;
      if (obs() !== 10'b1111_0_1_100_1) begin
         errors++;
         $display("FAIL all_ones got=%b expected=%b", obs(), 10'b1111_0_1_100_1);
      end
      step(1'b0, 1'b0, 4'b0000, 4'b1111);
      checks++;
      if (obs() !== 10'b1111_0_1_100_0) begin
         errors++;
         $display("FAIL hold got=%b expected=%b", obs(), 10'b1111_0_1_100_0);
      end
      step(1'b0, 1'b0, 4'bxxxx, 4'bzzzz);
      checks++;
      if (obs() !== 10'b1111_0_1_100_0) begin
         errors++;
         $display("FAIL hold_xz got=%b expected=%b", obs(), 10'b1111_0_1_100_0);
      end
   endtask

   task automatic test_reset_priority();
      step(1'b1, 1'b1, 4'b1111, 4'b1111);
      checks++;
      if (obs() !== 10'b0000_1_0_000_0) begin
         errors++;
         $display("FAIL reset_wins got=%b expected=%b", obs(), 10'b0000_1_0_000_0);
      end
      step(1'b0, 1'b1, 4'b0111, 4'b1011);
      checks++;
      if (obs() !== 10'b0011_0_0_010_1) begin
         errors++;
         $display("FAIL pre_midreset got=%b expected=%b", obs(), 10'b0011_0_0_010_1);
      end
      step(1'b1, 1'b1, 4'b1111, 4'b1111);
      checks++;
      if (obs() !== 10'b0000_1_0_000_0) begin
         errors++;
         $display("FAIL midreset got=%b expected=%b", obs(), 10'b0000_1_0_000_0);
      end
      step(1'b0, 1'b1, 4'b0110, 4'b1110);
      checks++;
      if (obs() !== 10'b0110_0_0_010_1) begin
         errors++;
         $display("FAIL post_midreset got=%b expected=%b", obs(), 10'b0110_0_0_010_1);
      end
   endtask

   task automatic test_exhaustive();
      for (int i = 0; i < 16; i++) begin
         for (int j = 0; j < 16; j++) begin
            logic [3:0] av, bv;
            av = i[3:0];
            bv = j[3:0];
            step(1'b0, 1'b1, av, bv);
            checks++;
            if (obs() !== pack_exp(av & bv, 1'b1)) begin
               errors++;
               $display("FAIL exh a=%b b=%b got=%b expected=%b", av, bv, obs(), pack_exp(av & bv, 1'b1));
            end
         end
      end
   endtask

   initial begin
      checks = 0;
      errors = 0;
      rst = 1'b1; in_valid = 1'b0; a = 4'b0000; b = 4'b0000;
      #1;
      test_reset();
      test_sweep(4'b1010);
      test_sweep(4'b1100);
      test_examples();
      test_hold();
      test_reset_priority();
      test_exhaustive();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/and4.md
AND4 -- requirements
Module: and4

Interface
REQ-001 SHALL have no parameters; the data width is fixed at 4 bits.
REQ-002 SHALL provide port clk, input, 1 bit: the single clock, with all state updating on the rising edge.
REQ-003 SHALL provide port rst, input, 1 bit: reset that is synchronous and active-high.
REQ-004 SHALL provide port a, input, 4 bits: operand A.
REQ-005 SHALL provide port b, input, 4 bits: operand B.
REQ-006 SHALL provide port in_valid, input, 1 bit: when high, a and b are captured on the current edge.
REQ-007 SHALL provide port y, output, 4 bits: registered bitwise AND result.
REQ-008 SHALL provide port out_valid, output, 1 bit: high for exactly the cycle after each accepted input.
REQ-009 SHALL provide port zero, output, 1 bit: registered flag, high when y == 4'b0000.
REQ-010 SHALL provide port all_ones, output, 1 bit: registered flag, high when y == 4'b1111.
REQ-011 SHALL provide port ones_cnt, output, 3 bits: registered population count of y (0..4).

Function
REQ-012 On a rising clk edge with rst low and in_valid high, y SHALL load a & b, bit by bit: y[i] = a[i] AND b[i] for i = 0..3.
REQ-013 Latency SHALL be exactly one clock: y, zero, all_ones and ones_cnt reflect the operands sampled on the previous edge.
REQ-014 On an edge with in_valid low, y, zero, all_ones and ones_cnt SHALL hold their previous values, and out_valid SHALL go low.
REQ-015 out_valid SHALL equal in_valid delayed by one clock (register of in_valid); there is no backpressure and every valid input is accepted.
REQ-016 zero, all_ones and ones_cnt SHALL be computed from the new a & b value and registered on the same edge as y, so they are always consistent with y.
REQ-017 ones_cnt SHALL be a 3-bit unsigned sum of the four result bits; no overflow is possible.
REQ-018 Outputs SHALL be pure functions of registered state, with no combinational path from a, b or in_valid to any output.
REQ-019 X or Z on a or b while in_valid is low SHALL NOT affect the outputs.
REQ-020 Back-to-back valid inputs on consecutive cycles SHALL each produce one result with out_valid held continuously high.

Reset
REQ-021 When rst is high at a rising edge, y SHALL become 4'b0000, zero SHALL become 1, all_ones SHALL become 0, ones_cnt SHALL become 0 and out_valid SHALL become 0.
REQ-022 rst SHALL take priority over in_valid: an input presented on a reset edge is discarded and produces no out_valid.
REQ-023 Reset asserted mid-stream SHALL discard any result not yet presented, and the first valid input after rst deasserts SHALL produce a result one cycle later.
REQ-024 Outputs SHALL be undefined only before the first reset edge; no asynchronous behaviour is permitted.

Verification
REQ-025 The bench SHALL apply rst high for 2 cycles, then low -> y=0000, zero=1, all_ones=0, ones_cnt=0, out_valid=0.
REQ-026 The bench SHALL hold b=1010 and sweep a=0..15 with in_valid high each cycle -> y one cycle later equals a & 1010 (for example, a=1111 gives y=1010 and ones_cnt=2; a=0101 gives y=0000 and zero=1).
REQ-027 The bench SHALL hold b=1100 and sweep a=0..15 -> y equals a & 1100 (for example, a=1110 gives y=1100), with out_valid high continuously after the first cycle.
REQ-028 The bench SHALL apply a=1111, b=1111, in_valid=1 -> y=1111, all_ones=1, ones_cnt=4; then drop in_valid with a=0000 -> y holds 1111 and out_valid=0.
REQ-029 The bench SHALL assert rst on the same edge as in_valid=1, a=1111, b=1111 -> y=0000 and out_valid=0 (reset wins).
REQ-030 The bench SHALL compare exhaustively all 256 (a, b) pairs against a reference AND, including the zero/all_ones/ones_cnt consistency check on every out_valid cycle.
